// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: FSM encodings and burst defaults.
package data_ram_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_HOST = 2'd2
  } arbState_t;

  localparam int DEF_MAX_BURST = 4;
  // Wide enough for counts up to the largest legal MAX_BURST (15).
  localparam int CNT_W = 4;
endpackage

// File: rtl/data_ram_arbiter_if.sv
// Requester-side bundle: core and host request ports, grants and read return.
interface data_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              iCoreReq, iCoreWe, iCoreLast;
  logic [ADDR_W-1:0] iCoreAddr;
  logic [DATA_W-1:0] iCoreData;
  logic              iHostReq, iHostWe, iHostLast;
  logic [ADDR_W-1:0] iHostAddr;
  logic [DATA_W-1:0] iHostData;
  logic              oCoreGnt, oHostGnt;
  logic              oCoreRdValid, oHostRdValid;
  logic [DATA_W-1:0] oRdData;

  modport slave (
    input  iCoreReq, iCoreWe, iCoreLast, iCoreAddr, iCoreData,
    input  iHostReq, iHostWe, iHostLast, iHostAddr, iHostData,
    output oCoreGnt, oHostGnt, oCoreRdValid, oHostRdValid, oRdData
  );

  modport master (
    output iCoreReq, iCoreWe, iCoreLast, iCoreAddr, iCoreData,
    output iHostReq, iHostWe, iHostLast, iHostAddr, iHostData,
    input  oCoreGnt, oHostGnt, oCoreRdValid, oHostRdValid, oRdData
  );
endinterface

// File: rtl/FFD_POSEDGE_SYNCRONOUS_RESET.sv
// Enabled D flip-flop bank with synchronous active-high reset.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
  parameter int SIZE = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [SIZE-1:0] D,
  output logic [SIZE-1:0] Q
);
  always_ff @(posedge Clock) begin
    if (Reset)       Q <= '0;
    else if (Enable) Q <= D;
  end
endmodule

// File: rtl/data_ram_arbiter_burst_counter.sv
// Beat counter for the active grant; flags the beat that must end the burst.
module arb_burst_counter
  import data_ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic beat,
  output logic forceRelease
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Reset)     count <= '0;
    else if (clear) count <= '0;
    else if (beat)  count <= count + 1'b1;
  end

  // With MAX_BURST=1 this is true on the very first beat of every grant.
  assign forceRelease = (count == CNT_W'(MAX_BURST - 1));
endmodule

// File: rtl/data_ram_arbiter.sv
// Fair core/host arbiter for the data RAM write port and read port 0.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              Clock,
  input  logic              Reset,
  data_ram_arbiter_if.slave bus,
  output logic              oRamWriteEnable,
  output logic [ADDR_W-1:0] oRamAddress,
  output logic [DATA_W-1:0] oRamData,
  input  logic [DATA_W-1:0] iRamData
);
  arbState_t         state, nextState;
  logic              rLastHost;
  logic              ownReq, ownWe, ownLast;
  logic [ADDR_W-1:0] ownAddr;
  logic [DATA_W-1:0] ownData;
  logic              beat, rdBeat, forceRelease;
  logic [1:0]        rdVld;
  logic [DATA_W-1:0] rdData;

  // Owner mux; the non-owner is invisible, and everything is 0 in IDLE.
  always_comb begin
    ownReq  = 1'b0;
    ownWe   = 1'b0;
    ownLast = 1'b0;
    ownAddr = '0;
    ownData = '0;
    unique case (state)
      ARB_CORE: begin
        ownReq  = bus.iCoreReq;
        ownWe   = bus.iCoreWe;
        ownLast = bus.iCoreLast;
        ownAddr = bus.iCoreAddr;
        ownData = bus.iCoreData;
      end
      ARB_HOST: begin
        ownReq  = bus.iHostReq;
        ownWe   = bus.iHostWe;
        ownLast = bus.iHostLast;
        ownAddr = bus.iHostAddr;
        ownData = bus.iHostData;
      end
      default: ;
    endcase
  end

  assign beat   = ownReq;
  assign rdBeat = beat & ~ownWe;

  always_comb begin
    nextState = state;
    unique case (state)
      ARB_IDLE: begin
        if (bus.iCoreReq && bus.iHostReq) nextState = rLastHost ? ARB_CORE : ARB_HOST;
        else if (bus.iCoreReq)            nextState = ARB_CORE;
        else if (bus.iHostReq)            nextState = ARB_HOST;
      end
      ARB_CORE, ARB_HOST: begin
        if (!ownReq || ownLast || forceRelease) nextState = ARB_IDLE;
      end
      default: nextState = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= ARB_IDLE;
      rLastHost <= 1'b1;
    end else begin
      state <= nextState;
      if (state != ARB_IDLE && nextState == ARB_IDLE) rLastHost <= (state == ARB_HOST);
    end
  end

  arb_burst_counter #(.MAX_BURST(MAX_BURST)) burstCnt (
    .Clock        (Clock),
    .Reset        (Reset),
    .clear        (state == ARB_IDLE),
    .beat         (beat),
    .forceRelease (forceRelease)
  );

  // Read return holds its data between read beats; valids pulse for one cycle.
  FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(DATA_W)) rdDataFf (
    .Clock  (Clock),
    .Reset  (~Reset),
    .Enable (rdBeat),
    .D      (iRamData),
    .Q      (rdData)
  );

  FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(2)) rdVldFf (
    .Clock  (Clock),
    .Reset  (~Reset),
    .Enable (1'b1),
    .D      ({rdBeat & (state == ARB_HOST), rdBeat & (state == ARB_CORE)}),
    .Q      (rdVld)
  );

  assign bus.oCoreGnt     = (state == ARB_CORE);
  assign bus.oHostGnt     = (state == ARB_HOST);
  assign bus.oCoreRdValid = rdVld[0];
  assign bus.oHostRdValid = rdVld[1];
  assign bus.oRdData      = rdData;

  assign oRamWriteEnable = beat & ownWe;
  assign oRamAddress     = ownAddr;
  assign oRamData        = ownData;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a 256x16 async-read RAM model.
module tb_data_ram_arbiter;
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  data_ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  logic        ramWe;
  logic [7:0]  ramAddr;
  logic [15:0] ramWData, ramRData;
  logic [15:0] mem [0:255];

  always @(posedge Clock) if (ramWe) mem[ramAddr] <= ramWData;
  assign ramRData = mem[ramAddr];

  data_ram_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(4)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .bus             (bus),
    .oRamWriteEnable (ramWe),
    .oRamAddress     (ramAddr),
    .oRamData        (ramWData),
    .iRamData        (ramRData)
  );

  int checks = 0;
  int failures = 0;

  task automatic cyc();
    @(negedge Clock);
  endtask

  task automatic setCore(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d, input logic l);
    bus.iCoreReq = r; bus.iCoreWe = w; bus.iCoreAddr = a; bus.iCoreData = d; bus.iCoreLast = l;
  endtask

  task automatic setHost(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d, input logic l);
    bus.iHostReq = r; bus.iHostWe = w; bus.iHostAddr = a; bus.iHostData = d; bus.iHostLast = l;
  endtask

  task automatic quiesce();
    cyc();
    setCore(0, 0, 8'h00, 16'h0000, 0);
    setHost(0, 0, 8'h00, 16'h0000, 0);
    repeat (2) cyc();
  endtask

  task automatic test_reset();
    setCore(1, 0, 8'h00, 16'h0000, 0);
    setHost(1, 0, 8'h00, 16'h0000, 0);
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      checks++; if (bus.oCoreGnt !== 1'b0) begin failures++; $display("FAIL rst_coreGnt got=%b exp=0", bus.oCoreGnt); end
      checks++; if (bus.oHostGnt !== 1'b0) begin failures++; $display("FAIL rst_hostGnt got=%b exp=0", bus.oHostGnt); end
      checks++; if ({bus.oCoreRdValid, bus.oHostRdValid} !== 2'b00) begin failures++; $display("FAIL rst_rdValid got=%b exp=00", {bus.oCoreRdValid, bus.oHostRdValid}); end
      checks++; if (ramWe !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", ramWe); end
    end
    checks++; if (bus.oRdData !== 16'h0000) begin failures++; $display("FAIL rst_rdData got=%h exp=0000", bus.oRdData); end
    cyc(); Reset = 1'b1; #1;
    cyc(); #1;
    checks++; if (bus.oCoreGnt !== 1'b1) begin failures++; $display("FAIL rst_firstTie_core got=%b exp=1", bus.oCoreGnt); end
    checks++; if (bus.oHostGnt !== 1'b0) begin failures++; $display("FAIL rst_firstTie_host got=%b exp=0", bus.oHostGnt); end
    quiesce();
  endtask

  task automatic test_core_write();
    logic [7:0]  a [3];
    logic [15:0] d [3];
    a[0] = 8'h10; a[1] = 8'h11; a[2] = 8'h12;
    d[0] = 16'hA5A5; d[1] = 16'h0001; d[2] = 16'hFFFF;
    setCore(1, 1, a[0], d[0], 0); #1;
    checks++; if ({bus.oCoreGnt, ramWe} !== 2'b00) begin failures++; $display("FAIL cw_preGrant got=%b exp=00", {bus.oCoreGnt, ramWe}); end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) cyc();
      setCore(1, 1, a[i], d[i], i == 2); #1;
      if (i == 0) begin cyc(); #1; end
      checks++; if (bus.oCoreGnt !== 1'b1) begin failures++; $display("FAIL cw_gnt%0d got=%b exp=1", i, bus.oCoreGnt); end
      checks++; if (ramWe !== 1'b1) begin failures++; $display("FAIL cw_we%0d got=%b exp=1", i, ramWe); end
      checks++; if (ramAddr !== a[i]) begin failures++; $display("FAIL cw_addr%0d got=%h exp=%h", i, ramAddr, a[i]); end
      checks++; if (ramWData !== d[i]) begin failures++; $display("FAIL cw_data%0d got=%h exp=%h", i, ramWData, d[i]); end
    end
    cyc(); setCore(1, 0, 8'h12, 16'h0000, 0); #1;
    checks++; if ({bus.oCoreGnt, ramWe} !== 2'b00) begin failures++; $display("FAIL cw_bubble got=%b exp=00", {bus.oCoreGnt, ramWe}); end
    checks++; if (ramAddr !== 8'h00) begin failures++; $display("FAIL cw_idleAddr got=%h exp=00", ramAddr); end
    cyc(); #1;
    checks++; if (bus.oCoreGnt !== 1'b1) begin failures++; $display("FAIL cw_regrant got=%b exp=1", bus.oCoreGnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[a[i]] !== d[i]) begin failures++; $display("FAIL cw_mem%0d got=%h exp=%h", i, mem[a[i]], d[i]); end
    end
    quiesce();
  endtask

  task automatic test_alternate();
    logic expCore, expHost;
    setCore(1, 0, 8'h10, 16'h0000, 0);
    setHost(1, 0, 8'h11, 16'h0000, 0); #1;
    checks++; if ({bus.oCoreGnt, bus.oHostGnt} !== 2'b00) begin failures++; $display("FAIL alt_idle0 got=%b exp=00", {bus.oCoreGnt, bus.oHostGnt}); end
    // Core was served last, so the host wins this tie: H4, idle, C4, idle, H4.
    for (int i = 1; i <= 14; i++) begin
      cyc(); #1;
      expHost = ((i - 1) % 5 != 4) && (((i - 1) / 5) % 2 == 0);
      expCore = ((i - 1) % 5 != 4) && (((i - 1) / 5) % 2 == 1);
      checks++;
      if ({bus.oCoreGnt, bus.oHostGnt} !== {expCore, expHost}) begin
        failures++; $display("FAIL alt_cycle%0d got core/host=%b exp=%b", i, {bus.oCoreGnt, bus.oHostGnt}, {expCore, expHost});
      end
    end
    quiesce();
  endtask

  task automatic test_host_read();
    setHost(1, 1, 8'h20, 16'h1234, 1); #1;
    checks++; if (bus.oHostGnt !== 1'b0) begin failures++; $display("FAIL hr_preGrant got=%b exp=0", bus.oHostGnt); end
    cyc(); #1;
    checks++; if ({bus.oHostGnt, ramWe} !== 2'b11) begin failures++; $display("FAIL hr_wrBeat got=%b exp=11", {bus.oHostGnt, ramWe}); end
    checks++; if ({ramAddr, ramWData} !== {8'h20, 16'h1234}) begin failures++; $display("FAIL hr_wrBus got=%h exp=201234", {ramAddr, ramWData}); end
    cyc(); setHost(1, 0, 8'h20, 16'h0000, 1); #1;
    checks++; if (bus.oHostGnt !== 1'b0) begin failures++; $display("FAIL hr_bubble got=%b exp=0", bus.oHostGnt); end
    cyc(); #1;
    checks++; if ({bus.oHostGnt, ramWe} !== 2'b10) begin failures++; $display("FAIL hr_rdBeat got=%b exp=10", {bus.oHostGnt, ramWe}); end
    checks++; if (ramAddr !== 8'h20) begin failures++; $display("FAIL hr_rdAddr got=%h exp=20", ramAddr); end
    cyc(); setHost(0, 0, 8'h00, 16'h0000, 0); #1;
    checks++; if (bus.oRdData !== 16'h1234) begin failures++; $display("FAIL hr_rdData got=%h exp=1234", bus.oRdData); end
    checks++; if (bus.oHostRdValid !== 1'b1) begin failures++; $display("FAIL hr_hostVld got=%b exp=1", bus.oHostRdValid); end
    checks++; if (bus.oCoreRdValid !== 1'b0) begin failures++; $display("FAIL hr_coreVld got=%b exp=0", bus.oCoreRdValid); end
    cyc(); #1;
    checks++; if (bus.oHostRdValid !== 1'b0) begin failures++; $display("FAIL hr_vldOneCycle got=%b exp=0", bus.oHostRdValid); end
    checks++; if (bus.oRdData !== 16'h1234) begin failures++; $display("FAIL hr_rdHold got=%h exp=1234", bus.oRdData); end
    quiesce();
  endtask

  task automatic test_host_abandon();
    setHost(1, 1, 8'h30, 16'hBEEF, 0); #1;
    cyc(); setCore(1, 1, 8'h40, 16'h5555, 1); #1;
    checks++; if ({bus.oHostGnt, ramWe} !== 2'b11) begin failures++; $display("FAIL ab_beat1 got=%b exp=11", {bus.oHostGnt, ramWe}); end
    checks++; if ({ramAddr, ramWData} !== {8'h30, 16'hBEEF}) begin failures++; $display("FAIL ab_ownerBus got=%h exp=30beef", {ramAddr, ramWData}); end
    cyc(); setHost(0, 1, 8'h31, 16'hDEAD, 0); #1;
    checks++; if ({bus.oHostGnt, ramWe} !== 2'b10) begin failures++; $display("FAIL ab_dropped got=%b exp=10", {bus.oHostGnt, ramWe}); end
    cyc(); #1;
    checks++; if ({bus.oCoreGnt, bus.oHostGnt, ramWe} !== 3'b000) begin failures++; $display("FAIL ab_idle got=%b exp=000", {bus.oCoreGnt, bus.oHostGnt, ramWe}); end
    cyc(); #1;
    checks++; if ({bus.oCoreGnt, bus.oHostGnt} !== 2'b10) begin failures++; $display("FAIL ab_coreGrant got=%b exp=10", {bus.oCoreGnt, bus.oHostGnt}); end
    checks++; if ({ramWe, ramAddr, ramWData} !== {1'b1, 8'h40, 16'h5555}) begin failures++; $display("FAIL ab_coreBeat got=%h exp=1405555", {ramWe, ramAddr, ramWData}); end
    quiesce();
    checks++; if (mem[8'h30] !== 16'hBEEF) begin failures++; $display("FAIL ab_mem30 got=%h exp=beef", mem[8'h30]); end
    checks++; if (mem[8'h40] !== 16'h5555) begin failures++; $display("FAIL ab_mem40 got=%h exp=5555", mem[8'h40]); end
  endtask

  task automatic test_reset_mid();
    setCore(1, 0, 8'h10, 16'h0000, 0); #1;
    cyc(); Reset = 1'b0; #1;
    checks++; if ({bus.oCoreGnt, ramWe} !== 2'b10) begin failures++; $display("FAIL rm_rdBeat got=%b exp=10", {bus.oCoreGnt, ramWe}); end
    cyc(); #1;
    checks++; if (bus.oCoreGnt !== 1'b0) begin failures++; $display("FAIL rm_gntDrop got=%b exp=0", bus.oCoreGnt); end
    checks++; if ({bus.oCoreRdValid, bus.oHostRdValid} !== 2'b00) begin failures++; $display("FAIL rm_vldSuppressed got=%b exp=00", {bus.oCoreRdValid, bus.oHostRdValid}); end
    checks++; if (bus.oRdData !== 16'h0000) begin failures++; $display("FAIL rm_rdDataReset got=%h exp=0000", bus.oRdData); end
    Reset = 1'b1;
    setHost(1, 0, 8'h11, 16'h0000, 0);
    cyc(); #1;
    checks++; if ({bus.oCoreGnt, bus.oHostGnt} !== 2'b10) begin failures++; $display("FAIL rm_tieCore got=%b exp=10", {bus.oCoreGnt, bus.oHostGnt}); end
    cyc(); setCore(0, 0, 8'h00, 16'h0000, 0); setHost(0, 0, 8'h00, 16'h0000, 0); #1;
    checks++; if (bus.oCoreRdValid !== 1'b1) begin failures++; $display("FAIL rm_coreVld got=%b exp=1", bus.oCoreRdValid); end
    checks++; if (bus.oRdData !== 16'hA5A5) begin failures++; $display("FAIL rm_rdData got=%h exp=a5a5", bus.oRdData); end
    checks++; if (bus.oHostRdValid !== 1'b0) begin failures++; $display("FAIL rm_hostVld got=%b exp=0", bus.oHostRdValid); end
    quiesce();
  endtask

  initial begin
    Reset = 1'b0;
    setCore(0, 0, 8'h00, 16'h0000, 0);
    setHost(0, 0, 8'h00, 16'h0000, 0);
    test_reset();
    test_core_write();
    test_alternate();
    test_host_read();
    test_host_abandon();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
